// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED wave scheduler: mode encoding,
// LED width and per-mode start patterns.
package led_sched_pkg;

   localparam int unsigned LED_COUNT = 6;

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      RIGHT  = 2'd1,
      LEFT   = 2'd2,
      BOUNCE = 2'd3
   } mode_t;

   localparam logic [LED_COUNT-1:0] START_OFF    = 6'b000000;
   localparam logic [LED_COUNT-1:0] START_RIGHT  = 6'b100000;
   localparam logic [LED_COUNT-1:0] START_LEFT   = 6'b000001;
   localparam logic [LED_COUNT-1:0] START_BOUNCE = 6'b000001;

   // Mode cycle order: OFF -> RIGHT -> LEFT -> BOUNCE -> OFF
   function automatic mode_t next_mode(input mode_t m);
      mode_t r;
      unique case (m)
         OFF:     r = RIGHT;
         RIGHT:   r = LEFT;
         LEFT:    r = BOUNCE;
         default: r = OFF;
      endcase
      return r;
   endfunction

   function automatic logic [LED_COUNT-1:0] start_pattern(input mode_t m);
      logic [LED_COUNT-1:0] r;
      unique case (m)
         OFF:     r = START_OFF;
         RIGHT:   r = START_RIGHT;
         LEFT:    r = START_LEFT;
         default: r = START_BOUNCE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus level debouncer for a raw push button;
// emits the accepted level and a one-cycle pulse on its rising edge.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_async,
   output logic level,
   output logic rise_pulse
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count consecutive samples that disagree with the accepted level
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      rise_d = level_d & ~level_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_async;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level      = level_q;
   assign rise_pulse = rise_q;

endmodule

// File: rtl/led_wave_scheduler.sv
// Button-driven LED pattern scheduler: prescaled step strobe, four display
// modes and a debounced mode-advance button. LED_ACTIVE_LOW_EN inverts LED.
module led_wave_scheduler
   import led_sched_pkg::*;
#(
   parameter int unsigned CLK_DIV         = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 btn_next,
   output logic [LED_COUNT-1:0] LED,
   output logic [1:0]           mode,
   output logic                 tick
);

   localparam int unsigned PS_W = $clog2(CLK_DIV);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);

   logic                 btn_level, btn_rise, next_req;
   mode_t                mode_q, mode_d;
   logic [LED_COUNT-1:0] pat_q, pat_d;
   logic                 dir_up_q, dir_up_d;
   logic [PS_W-1:0]      pre_q, pre_d;
   logic                 tick_q, tick_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn (
      .clk        (clk),
      .rst        (rst),
      .btn_async  (btn_next),
      .level      (btn_level),
      .rise_pulse (btn_rise)
   );

   // Rise pulse is only honoured while the accepted level is still high
   assign next_req = btn_rise & btn_level;

   // Mode change takes precedence over a coincident step
   always_comb begin
      mode_d   = mode_q;
      pat_d    = pat_q;
      dir_up_d = dir_up_q;
      pre_d    = tick_q ? '0 : pre_q + PS_W'(1);
      if (next_req) begin
         mode_d   = next_mode(mode_q);
         pat_d    = start_pattern(mode_d);
         dir_up_d = 1'b1;
         pre_d    = '0;
      end else if (tick_q) begin
         unique case (mode_q)
            RIGHT:  pat_d = {pat_q[0], pat_q[LED_COUNT-1:1]};
            LEFT:   pat_d = {pat_q[LED_COUNT-2:0], pat_q[LED_COUNT-1]};
            BOUNCE: begin
               if (dir_up_q) begin
                  pat_d = pat_q << 1;
                  if (pat_d[LED_COUNT-1]) dir_up_d = 1'b0;
               end else begin
                  pat_d = pat_q >> 1;
                  if (pat_d[0]) dir_up_d = 1'b1;
               end
            end
            default: pat_d = START_OFF;
         endcase
      end
      tick_d = (pre_d == PS_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q   <= RIGHT;
         pat_q    <= START_RIGHT;
         dir_up_q <= 1'b1;
         pre_q    <= '0;
         tick_q   <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         pat_q    <= pat_d;
         dir_up_q <= dir_up_d;
         pre_q    <= pre_d;
         tick_q   <= tick_d;
      end
   end

`ifdef LED_ACTIVE_LOW_EN
   assign LED = ~pat_q;
`else
   assign LED = pat_q;
`endif
   assign mode = mode_q;
   assign tick = tick_q;

endmodule

// File: tb/tb_led_wave_scheduler.sv
// Randomized and directed bench for led_wave_scheduler against a
// cycles-since-mode-entry reference model with a run-length button model.
module tb_led_wave_scheduler;

   localparam int CLK_DIV = 4;
   localparam int DEB     = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_next;
   logic [5:0] LED;
   logic [1:0] mode;
   logic       tick;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int   m_mode, m_c, m_run_len, m_coinc;
   logic m_d1, m_d2, m_run_val, m_lvl, m_pend;

   led_wave_scheduler #(.CLK_DIV(CLK_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_next (btn_next),
      .LED      (LED),
      .mode     (mode),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pattern after c cycles in a mode: one step every CLK_DIV cycles
   function automatic logic [5:0] exp_pat(input int md, input int c);
      int t, p;
      logic [5:0] one, top;
      one = 6'd1;
      top = 6'd32;
      t = c / CLK_DIV;
      case (md)
         1: begin p = t % 6;  return top >> p; end
         2: begin p = t % 6;  return one << p; end
         3: begin p = t % 10; return (p <= 5) ? (one << p) : (one << (10 - p)); end
         default: return 6'd0;
      endcase
   endfunction

   function automatic logic [5:0] exp_led(input int md, input int c);
`ifdef LED_ACTIVE_LOW_EN
      return ~exp_pat(md, c);
`else
      return exp_pat(md, c);
`endif
   endfunction

   task automatic model_reset();
      m_mode = 1; m_c = 0;
      m_d1 = 1'b0; m_d2 = 1'b0;
      m_run_val = 1'b0; m_run_len = 0;
      m_lvl = 1'b0; m_pend = 1'b0;
   endtask

   // One rising edge; b is the button level sampled at this edge
   task automatic model_edge(input logic b);
      logic s, np;
      if (m_pend) begin
         if (m_c % CLK_DIV == CLK_DIV - 1) m_coinc++;
         m_mode = (m_mode + 1) % 4;
         m_c = 0;
      end else begin
         m_c++;
      end
      s = m_d2; m_d2 = m_d1; m_d1 = b;
      if (s == m_run_val) m_run_len++;
      else begin m_run_val = s; m_run_len = 1; end
      np = 1'b0;
      if (s != m_lvl && m_run_len >= DEB) begin
         m_lvl = s;
         np = s;
      end
      m_pend = np;
   endtask

   task automatic check_outputs();
      check("led",  {2'b0, LED},  {2'b0, exp_led(m_mode, m_c)});
      check("mode", {6'b0, mode}, 8'(m_mode));
      check("tick", {7'b0, tick}, {7'b0, (m_c % CLK_DIV == CLK_DIV - 1)});
   endtask

   task automatic cyc(input logic b);
      btn_next = b;
      @(posedge clk);
      model_edge(b);
      #1;
      check_outputs();
   endtask

   // Asserts rst away from an edge, checks it acts immediately, then releases
   task automatic do_reset(input logic b);
      btn_next = b;
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_mode", {6'b0, mode}, 8'd1);
      check("rst_led",  {2'b0, LED},  {2'b0, exp_led(1, 0)});
      check("rst_tick", {7'b0, tick}, 8'd0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      int   lat, adv;
      logic [1:0] prev_mode;
      logic found;
      logic b;
      int   len;

      rst = 1'b0;
      btn_next = 1'b0;
      m_coinc = 0;
      #2;
      do_reset(1'b0);

      // free-running RIGHT rotation, full period and beyond
      for (int i = 0; i < 26; i++) cyc(1'b0);

      // short glitch must not advance
      cyc(1'b1); cyc(1'b1);
      for (int i = 0; i < 8; i++) cyc(1'b0);
      check("glitch_mode", {6'b0, mode}, 8'd1);

      // held press: one advance, bounded latency
      lat = 0; adv = 0; prev_mode = mode;
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1);
         if (mode != prev_mode) begin
            adv++;
            if (lat == 0) lat = i + 1;
         end
         prev_mode = mode;
      end
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0);
         if (mode != prev_mode) adv++;
         prev_mode = mode;
      end
      check("press_latency_ok", {7'b0, (lat >= 4 && lat <= 7)}, 8'd1);
      check("press_advances", 8'(adv), 8'd1);
      check("press_mode", {6'b0, mode}, 8'd2);

      // to BOUNCE, watch more than one full bounce period
      for (int i = 0; i < 8; i++) cyc(1'b1);
      for (int i = 0; i < 44; i++) cyc(1'b0);
      check("bounce_mode", {6'b0, mode}, 8'd3);

      // reach LEFT at 001000, then reset mid-cycle
      do_reset(1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b1);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         cyc(1'b0);
         if (m_mode == 2 && exp_pat(m_mode, m_c) == 6'b001000) found = 1'b1;
      end
      check("found_left_001000", {7'b0, found}, 8'd1);
      #3;
      do_reset(1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b0);

      // sweep press phase so one mode change lands on a tick;
      // first pass holds the button through reset release
      for (int off = 0; off < 4; off++) begin
         do_reset(off == 0);
         for (int i = 0; i < off; i++) cyc(off == 0);
         for (int i = 0; i < 10; i++) cyc(1'b1);
         for (int i = 0; i < 20; i++) cyc(1'b0);
         check("sweep_mode", {6'b0, mode}, 8'd2);
      end
      check("coincident_seen", {7'b0, (m_coinc > 0)}, 8'd1);

      // random button bursts
      for (int k = 0; k < 60; k++) begin
         b   = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 10);
         for (int i = 0; i < len; i++) cyc(b);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
